// File: rtl/soc_sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM encoding, Avalon word
// addresses and the default expected register values.
`timescale 1ns/1ps

package soc_sysid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        FIN   = 2'd3
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXPECTED_ID_DEFAULT = 32'd0;
    localparam logic [31:0] SYSID_EXPECTED_TS_DEFAULT = 32'd1644647012;
    localparam logic [15:0] SYSID_TIMEOUT_DEFAULT     = 16'd255;

    // Result set published together at the end of every check.
    typedef struct packed {
        logic        id_ok;
        logic        ts_ok;
        logic [31:0] id;
        logic [31:0] ts;
    } sysid_result_t;

endpackage

// File: rtl/soc_sysid_checker_if.sv
// Avalon-MM read-only port used by the system-ID checker (checker is master).
`timescale 1ns/1ps

interface soc_sysid_checker_if;

    logic        av_address;
    logic        av_read;
    logic [31:0] av_readdata;
    logic        av_waitrequest;

    modport master (
        output av_address,
        output av_read,
        input  av_readdata,
        input  av_waitrequest
    );

    modport slave (
        input  av_address,
        input  av_read,
        output av_readdata,
        output av_waitrequest
    );

endinterface

// File: rtl/soc_sysid_checker.sv
// Reads the system-ID and timestamp words over Avalon-MM and compares them with
// the expected values. Optional stall timeout: define SYSID_CHECK_TIMEOUT_EN.
`timescale 1ns/1ps

module soc_sysid_checker
    import soc_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID_DEFAULT,
    parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS_DEFAULT,
    parameter logic [15:0] TIMEOUT_CYCLES = SYSID_TIMEOUT_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        id_ok,
    output logic                        ts_ok,
    output logic                        timeout,
    output logic [31:0]                 read_id,
    output logic [31:0]                 read_ts,
    soc_sysid_checker_if.master         av
);

    sysid_state_t  state_q, state_d;
    sysid_result_t res_q, res_d;
    logic          res_load;
    logic [31:0]   id_shadow_q;
    logic          rd_active;
    logic          rd_addr;
    logic          stall_hit;
    logic          read_start;

    // A new read begins whenever the FSM moves into one of the read states.
    assign read_start = (state_d != state_q) &&
                        ((state_d == RD_ID) || (state_d == RD_TS));

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic [15:0] stall_cnt_q;
    logic        timeout_q;

    assign stall_hit = (stall_cnt_q >= TIMEOUT_CYCLES);

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            if (read_start) begin
                stall_cnt_q <= 16'd0;
            end else if (av.av_read && av.av_waitrequest) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (res_load) begin
                timeout_q <= stall_hit;
            end
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    // The limit has no effect when reads are allowed to wait forever.
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign stall_hit          = 1'b0;
    assign timeout            = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        res_load  = 1'b0;
        rd_active = 1'b0;
        rd_addr   = SYSID_ADDR_ID;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_ID;
                end
            end

            RD_ID: begin
                rd_active = !stall_hit;
                if (stall_hit) begin
                    state_d  = FIN;
                    res_load = 1'b1;
                    res_d    = '{id_ok: 1'b0, ts_ok: 1'b0, id: 32'd0, ts: 32'd0};
                end else if (!av.av_waitrequest) begin
                    state_d = RD_TS;
                end
            end

            RD_TS: begin
                rd_addr   = SYSID_ADDR_TS;
                rd_active = !stall_hit;
                if (stall_hit) begin
                    state_d  = FIN;
                    res_load = 1'b1;
                    res_d    = '{id_ok: 1'b0, ts_ok: 1'b0, id: id_shadow_q, ts: 32'd0};
                end else if (!av.av_waitrequest) begin
                    state_d  = FIN;
                    res_load = 1'b1;
                    res_d    = '{id_ok: (id_shadow_q == EXPECTED_ID),
                                 ts_ok: (av.av_readdata == EXPECTED_TS),
                                 id:    id_shadow_q,
                                 ts:    av.av_readdata};
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            res_q       <= '0;
            id_shadow_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == RD_ID) && (state_d == RD_TS)) begin
                id_shadow_q <= av.av_readdata;
            end
            if (res_load) begin
                res_q <= res_d;
            end
        end
    end

    assign av.av_read    = rd_active;
    assign av.av_address = rd_addr;

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);
    assign id_ok   = res_q.id_ok;
    assign ts_ok   = res_q.ts_ok;
    assign read_id = res_q.id;
    assign read_ts = res_q.ts;

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Self-checking bench for soc_sysid_checker: behavioural Avalon slave with
// programmable waitstates, directed scenarios and randomized checks.
`timescale 1ns/1ps

module tb_soc_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1644647012;
    localparam logic [15:0] TMO    = 16'd8;
    localparam int          BUDGET = 400;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] read_id, read_ts;

    soc_sysid_checker_if bus ();

    soc_sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .id_ok   (id_ok),
        .ts_ok   (ts_ok),
        .timeout (timeout),
        .read_id (read_id),
        .read_ts (read_ts),
        .av      (bus)
    );

    always #5 clock = ~clock;

    // Behavioural slave: each read stalls for wait_* cycles, then returns the
    // word for its address; junk is presented while stalled.
    logic [31:0] mem_id, mem_ts;
    int          wait_id, wait_ts;
    int          stall_seen;
    int          cur_wait;

    always_comb begin
        cur_wait = bus.av_address ? wait_ts : wait_id;
    end

    assign bus.av_waitrequest = bus.av_read && (stall_seen < cur_wait);
    assign bus.av_readdata    = bus.av_waitrequest ? 32'hBAD0_BAD0 :
                                (bus.av_address ? mem_ts : mem_id);

    always @(posedge clock) begin
        if (reset || !bus.av_read || !bus.av_waitrequest) stall_seen <= 0;
        else                                              stall_seen <= stall_seen + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full check; expected timing and results come from the protocol rules:
    // each read lasts (waits + 1) cycles, FIN adds one more.
    task automatic run_check(input logic [31:0] id_v, input logic [31:0] ts_v,
                             input int w_id, input int w_ts, input string tag);
        int cyc;
        mem_id  = id_v;
        mem_ts  = ts_v;
        wait_id = w_id;
        wait_ts = w_ts;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < BUDGET) begin
            check({tag, ".av_read"}, bus.av_read, 1'b1);
            check({tag, ".av_address"}, bus.av_address, (cyc > w_id + 1) ? 1'b1 : 1'b0);
            check({tag, ".busy"}, busy, 1'b1);
            @(negedge clock);
            cyc++;
        end
        check({tag, ".latency"}, cyc, 3 + w_id + w_ts);
        check({tag, ".id_ok"}, id_ok, (id_v == EXP_ID));
        check({tag, ".ts_ok"}, ts_ok, (ts_v == EXP_TS));
        check({tag, ".timeout"}, timeout, 1'b0);
        check({tag, ".read_id"}, read_id, id_v);
        check({tag, ".read_ts"}, read_ts, ts_v);
        check({tag, ".fin_read"}, bus.av_read, 1'b0);
        @(negedge clock);
        check({tag, ".done_pulse"}, done, 1'b0);
        check({tag, ".busy_idle"}, busy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".done"}, done, 1'b0);
        check({tag, ".av_read"}, bus.av_read, 1'b0);
        check({tag, ".av_address"}, bus.av_address, 1'b0);
        check({tag, ".id_ok"}, id_ok, 1'b0);
        check({tag, ".ts_ok"}, ts_ok, 1'b0);
        check({tag, ".timeout"}, timeout, 1'b0);
        check({tag, ".read_id"}, read_id, 32'd0);
        check({tag, ".read_ts"}, read_ts, 32'd0);
    endtask

    initial begin
        int cyc;
        int n_done;
        int n_read;
        logic [31:0] rid, rts;

        reset   = 1'b1;
        start   = 1'b0;
        mem_id  = 32'd0;
        mem_ts  = 32'd0;
        wait_id = 0;
        wait_ts = 0;
        repeat (3) @(negedge clock);
        check_reset_state("por");
        reset = 1'b0;

        run_check(EXP_ID, EXP_TS, 0, 0, "nowait");
        run_check(EXP_ID, 32'd1644647013, 0, 0, "ts_bad");
        run_check(EXP_ID, EXP_TS, 5, 5, "wait5");
        run_check(32'h0000_0001, EXP_TS, 2, 0, "id_bad");
        run_check(32'hFFFF_FFFF, ~EXP_TS, 0, 3, "all_bad");

        for (int i = 0; i < 20; i++) begin
            rid = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            rts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            run_check(rid, rts, $urandom_range(0, 4), $urandom_range(0, 4), "rand");
        end

        // Slave stuck in waitrequest on the first read.
        mem_id  = EXP_ID;
        mem_ts  = EXP_TS;
        wait_id = 1000000;
        wait_ts = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        cyc    = 1;
        n_read = 0;
`ifdef SYSID_CHECK_TIMEOUT_EN
        while (!done && cyc < BUDGET) begin
            if (bus.av_read) n_read++;
            @(negedge clock);
            cyc++;
        end
        check("tmo.latency", cyc, int'(TMO) + 2);
        check("tmo.read_cycles", n_read, int'(TMO));
        check("tmo.timeout", timeout, 1'b1);
        check("tmo.id_ok", id_ok, 1'b0);
        check("tmo.ts_ok", ts_ok, 1'b0);
        @(negedge clock);
        check("tmo.busy_idle", busy, 1'b0);
        wait_id = 0;
`else
        n_done = 0;
        repeat (300) begin
            if (done) n_done++;
            @(negedge clock);
        end
        check("stuck.no_done", n_done, 0);
        check("stuck.busy", busy, 1'b1);
        check("stuck.av_read", bus.av_read, 1'b1);
        check("stuck.av_address", bus.av_address, 1'b0);
        check("stuck.timeout", timeout, 1'b0);
        wait_id = 0;
        cyc     = 0;
        while (!done && cyc < BUDGET) begin
            @(negedge clock);
            cyc++;
        end
        // Released in the cycle just sampled: that read completes, then RD_TS, FIN.
        check("stuck.release_latency", cyc, 2);
        check("stuck.id_ok", id_ok, 1'b1);
        check("stuck.ts_ok", ts_ok, 1'b1);
        @(negedge clock);
`endif
        run_check(EXP_ID, EXP_TS, 1, 1, "after_stall");

        // start held high throughout the check, including the done cycle.
        mem_id  = EXP_ID;
        mem_ts  = EXP_TS;
        wait_id = 1;
        wait_ts = 0;
        @(negedge clock);
        start  = 1'b1;
        n_done = 0;
        cyc    = 0;
        while (n_done == 0 && cyc < BUDGET) begin
            @(negedge clock);
            cyc++;
            if (done) n_done++;
        end
        @(negedge clock);
        start = 1'b0;
        check("restart.idle_after_done", busy, 1'b0);
        repeat (8) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("restart.one_check", n_done, 1);

        // Reset while the timestamp read is stalled.
        mem_id  = EXP_ID;
        mem_ts  = EXP_TS;
        wait_id = 0;
        wait_ts = 5;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc   = 0;
        while (!(bus.av_read && bus.av_address && bus.av_waitrequest) && cyc < BUDGET) begin
            @(negedge clock);
            cyc++;
        end
        check("rst.reached_ts_stall", busy, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_state("rst");
        reset  = 1'b0;
        n_done = 0;
        repeat (10) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("rst.no_done", n_done, 0);

        run_check(EXP_ID, EXP_TS, 0, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/soc_sysid_checker.md
SOC_SYSID_CHECKER -- requirements
Module: soc_sysid_checker

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- EXPECTED_ID, 32'd0: value required at word address 0.
- EXPECTED_TS, 32'd1644647012: value required at word address 1.
- TIMEOUT_CYCLES, 16'd255: maximum stalled cycles per read.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning (clock and reset first).
- clock, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle request to run a check.
- busy, out, 1: high while a check is in progress.
- done, out, 1: one-cycle pulse when a check ends.
- id_ok, out, 1: captured ID equals EXPECTED_ID.
- ts_ok, out, 1: captured timestamp equals EXPECTED_TS.
- timeout, out, 1: last check aborted on stall.
- read_id, out, 32: captured address-0 data.
- read_ts, out, 32: captured address-1 data.
- av_address, out, 1: Avalon-MM word address.
- av_read, out, 1: Avalon-MM read strobe.
- av_readdata, in, 32: Avalon-MM read data.
- av_waitrequest, in, 1: Avalon-MM stall.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, RD_ID, RD_TS and FIN.
REQ-004 start sampled high in IDLE SHALL move the FSM to RD_ID on the next edge; start SHALL be ignored in every other state.
REQ-005 In RD_ID the block SHALL drive av_read=1 and av_address=0; in RD_TS it SHALL drive av_read=1 and av_address=1; in all other states av_read SHALL be 0 and av_address SHALL be 0.
REQ-006 av_read and av_address SHALL stay stable while av_waitrequest=1.
REQ-007 A read SHALL complete in the first cycle with av_read=1 and av_waitrequest=0, with zero-latency capture of av_readdata in that cycle: into read_id, then to RD_TS; or into read_ts, then to FIN.
REQ-008 In FIN, done SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE; id_ok, ts_ok, timeout, read_id and read_ts SHALL be updated at the FIN entry edge and held until the next FIN.
REQ-009 id_ok SHALL equal (read_id==EXPECTED_ID) and ts_ok SHALL equal (read_ts==EXPECTED_TS), compared over the full 32 bits; on timeout both SHALL be 0.
REQ-010 busy SHALL be 1 in RD_ID, RD_TS and FIN, and 0 in IDLE.
REQ-011 Minimum start-to-done latency SHALL be 3 cycles (RD_ID, RD_TS, FIN), with no waitstates.
REQ-012 A start pulse arriving in the same cycle as done SHALL be ignored.

Reset
REQ-013 With reset high at a clock edge: FSM=IDLE; busy, done, av_read, av_address, id_ok, ts_ok and timeout SHALL be 0; read_id and read_ts SHALL be 32'd0; the stall counter SHALL be 0.
REQ-014 Reset asserted mid-read SHALL drop av_read in the next cycle without producing done.

Configuration
REQ-015 With macro SYSID_CHECK_TIMEOUT_EN defined, a 16-bit stall counter SHALL count cycles with av_read=1 and av_waitrequest=1, and clear at each read start.
REQ-016 With SYSID_CHECK_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES the block SHALL deassert av_read, set timeout=1, and enter FIN.
REQ-017 Without SYSID_CHECK_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be constant 0, and reads SHALL wait indefinitely.

Structure
REQ-018 A shared package soc_sysid_pkg SHALL hold the FSM state encoding, SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1 and the default EXPECTED_* constants.
REQ-019 The design SHALL be a single module with no sub-module; the timeout counter is inline logic under the macro.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- No waitstates, slave returns 0 and 1644647012: start -> done at cycle 3; id_ok=1, ts_ok=1, timeout=0.
- Slave returns 0 and 1644647013: ts_ok=0, id_ok=1, read_ts=1644647013.
- Waitrequest held 5 cycles on each read: done at cycle 13; address and read stable during the stall; both ok flags 1.
- Macro defined, TIMEOUT_CYCLES=8, waitrequest stuck high: done after 9 cycles in RD_ID; timeout=1, id_ok=0, ts_ok=0.
- Reset pulsed during the RD_TS stall: av_read=0 next cycle, no done pulse, all outputs at reset values.
- start repeated while busy, and start in the done cycle: exactly one check runs.
